// File: rtl/ram_wb_arbiter.sv
// Two-master Wishbone classic round-robin arbiter in front of the single-port RAM.
// Optional slave-ack timeout with error termination: define RAM_ARB_TIMEOUT_EN.
module ram_wb_arbiter #(
    parameter int aw      = 10,
    parameter int TIMEOUT = 15
) (
    input  logic          i_wb_clk,
    input  logic          i_rst_n,
    input  logic [aw-1:2] i_m0_adr,
    input  logic [31:0]   i_m0_dat,
    input  logic [3:0]    i_m0_sel,
    input  logic          i_m0_we,
    input  logic          i_m0_cyc,
    output logic [31:0]   o_m0_rdt,
    output logic          o_m0_ack,
    output logic          o_m0_err,
    input  logic [aw-1:2] i_m1_adr,
    input  logic [31:0]   i_m1_dat,
    input  logic [3:0]    i_m1_sel,
    input  logic          i_m1_we,
    input  logic          i_m1_cyc,
    output logic [31:0]   o_m1_rdt,
    output logic          o_m1_ack,
    output logic          o_m1_err,
    output logic [aw-1:2] o_s_adr,
    output logic [31:0]   o_s_dat,
    output logic [3:0]    o_s_sel,
    output logic          o_s_we,
    output logic          o_s_cyc,
    input  logic [31:0]   i_s_rdt,
    input  logic          i_s_ack
);

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } state_t;

    state_t r_state;
    logic   r_last_gnt;
    logic   w_gnt0;
    logic   w_gnt1;
    logic   w_tmo;

    assign w_gnt0 = (r_state == GNT0);
    assign w_gnt1 = (r_state == GNT1);

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // IDLE always precedes a grant, so clearing here covers every grant entry.
    always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else if (!i_s_ack) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign w_tmo    = (r_cnt == CW'(TIMEOUT));
    assign o_m0_err = w_gnt0 & i_m0_cyc & ~i_s_ack & w_tmo;
    assign o_m1_err = w_gnt1 & i_m1_cyc & ~i_s_ack & w_tmo;
`else
    assign w_tmo    = 1'b0;
    assign o_m0_err = 1'b0;
    assign o_m1_err = 1'b0;
`endif

    always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_m0_cyc && (!i_m1_cyc || r_last_gnt)) begin
                        r_state    <= GNT0;
                        r_last_gnt <= 1'b0;
                    end else if (i_m1_cyc) begin
                        r_state    <= GNT1;
                        r_last_gnt <= 1'b1;
                    end
                end
                GNT0: begin
                    if (i_s_ack || !i_m0_cyc || w_tmo) r_state <= IDLE;
                end
                GNT1: begin
                    if (i_s_ack || !i_m1_cyc || w_tmo) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Master 0 owns the slave-side address/data mux whenever master 1 is not granted.
    assign o_s_adr = w_gnt1 ? i_m1_adr : i_m0_adr;
    assign o_s_dat = w_gnt1 ? i_m1_dat : i_m0_dat;
    assign o_s_sel = w_gnt1 ? i_m1_sel : i_m0_sel;
    assign o_s_cyc = (w_gnt0 & i_m0_cyc) | (w_gnt1 & i_m1_cyc);
    assign o_s_we  = (w_gnt0 & i_m0_cyc & i_m0_we) | (w_gnt1 & i_m1_cyc & i_m1_we);

    assign o_m0_ack = w_gnt0 & i_s_ack & i_m0_cyc;
    assign o_m1_ack = w_gnt1 & i_s_ack & i_m1_cyc;
    assign o_m0_rdt = i_s_rdt;
    assign o_m1_rdt = i_s_rdt;

endmodule

// File: doc/ram_wb_arbiter.md
Name: ram_wb_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter that shares the single-port on-chip RAM between two requesters: master 0 (CPU data bus) and master 1 (loader/DMA port).
- Round-robin grant with a registered grant state machine.
- Drives the RAM's single-cycle-ack slave interface and routes ack/read data back to the granted master only.
- Sits directly in front of the RAM.

Parameters:
- aw, 10, byte-address width of the RAM; master and slave address ports are [aw-1:2].
- TIMEOUT, 15, cycles without slave ack before an error termination (used only with the optional feature); counter width $clog2(TIMEOUT+1).

Ports:
- i_wb_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_m0_adr  in  aw-2  master 0 word address
- i_m0_dat  in  32  master 0 write data
- i_m0_sel  in  4  master 0 byte enables
- i_m0_we  in  1  master 0 write enable
- i_m0_cyc  in  1  master 0 request, held until ack/err
- o_m0_rdt  out  32  master 0 read data
- o_m0_ack  out  1  master 0 acknowledge
- o_m0_err  out  1  master 0 error termination
- i_m1_adr / i_m1_dat / i_m1_sel / i_m1_we / i_m1_cyc  in  aw-2/32/4/1/1  master 1, same meaning as master 0
- o_m1_rdt / o_m1_ack / o_m1_err  out  32/1/1  master 1, same meaning as master 0
- o_s_adr  out  aw-2  to RAM address
- o_s_dat  out  32  to RAM write data
- o_s_sel  out  4  to RAM byte enables
- o_s_we  out  1  to RAM write enable
- o_s_cyc  out  1  to RAM cycle
- i_s_rdt  in  32  RAM read data
- i_s_ack  in  1  RAM ack

Behaviour:
- States: IDLE, GNT0, GNT1. Register last_gnt (1 bit).
- Reset (async, i_rst_n=0): state=IDLE, last_gnt=1 (master 0 wins first tie), timeout counter=0.
- Reset mid-transfer drops o_s_cyc immediately; no ack is delivered.
- IDLE transitions:
  - only m0_cyc → GNT0; only m1_cyc → GNT1.
  - both → the master != last_gnt.
  - none → stay in IDLE.
  - On entering GNTx, last_gnt <= x.
- GNTx transitions:
  - i_s_ack=1 → IDLE.
  - i_mx_cyc=0 (abort) → IDLE, nothing forwarded.
  - Otherwise hold.
- Mandatory IDLE cycle between grants, so o_s_cyc is low ≥1 cycle between transfers; the RAM's ack toggle never straddles two masters.
- Slave mux (combinational from state):
  - o_s_adr/dat/sel/we = granted master's signals; master 0's signals in IDLE.
  - o_s_cyc = (GNT0 & i_m0_cyc) | (GNT1 & i_m1_cyc).
  - o_s_we is qualified the same way.
- Return path:
  - o_mx_ack = (state==GNTx) & i_s_ack & i_mx_cyc.
  - o_m0_rdt = o_m1_rdt = i_s_rdt (broadcast; valid only with own ack).
  - i_s_ack while IDLE is ignored.
- Latency, uncontended: master cyc rises cycle 0 → GNT at edge 1 → o_s_cyc cycle 1 → RAM ack + rdt in cycle 2 → master ack cycle 2 → IDLE cycle 3. Throughput one transfer per 3 cycles.
- Both masters continuously requesting → strict alternation 0,1,0,1…; neither starves.
- Master requests during another's grant wait; no request is lost.
- A master must not change adr/dat/sel/we while cyc is high; the arbiter does not register them.

Optional Feature:
- Macro RAM_ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on entering GNTx and increments each GNT cycle without i_s_ack.
  - Counter reaching TIMEOUT → o_mx_err=1 for exactly one cycle (registered-state qualified, combinational output in that cycle), state → IDLE, o_s_cyc drops next cycle.
  - err and ack are never both high.
- Undefined: no counter logic; o_m0_err=o_m1_err=0 constantly; ports still present.

Test Plan:
- Reset then m0 read adr 0x004, RAM holds 0xDEADBEEF → o_s_cyc high cycle 1, o_m0_ack and o_m0_rdt=0xDEADBEEF in cycle 2, o_m1_ack never asserts.
- m0 and m1 assert cyc same cycle after reset, m0 writes 0x11223344 sel=0xF to 0x008, m1 reads 0x008 → m0 granted first, m1 granted after one IDLE cycle, m1 rdt=0x11223344.
- Both masters hold cyc for 6 transfers → grant order 0,1,0,1,0,1; o_s_cyc low exactly one cycle between each.
- m1 drops cyc in its first GNT1 cycle (abort) → o_s_cyc low next cycle, no o_m1_ack, pending m0 granted after IDLE.
- i_rst_n pulsed low while GNT0 with o_s_cyc high → o_s_cyc and all acks 0 immediately; after release m0 wins the first tie.
- RAM_ARB_TIMEOUT_EN defined, TIMEOUT=4, slave ack stuck low → o_m0_err high for one cycle after 4 GNT0 cycles, then IDLE. Without the macro, same stimulus → err stays 0 and the grant holds.
